// File: rtl/pix_buff_rd_arb.sv
// Round-robin burst arbiter sharing the pixel-buffer prefetch FIFO read port
// among N_REQ consumers; one grant at a time, at most BURST_LEN beats each.
module pix_buff_rd_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16,
  localparam int ID_W     = $clog2(N_REQ),
  localparam int CNT_W    = $clog2(BURST_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_REQ-1:0]  req_i,
  input  logic [N_REQ-1:0]  cons_rdy_i,
  output logic [N_REQ-1:0]  cons_vld_o,
  output logic [DATA_W-1:0] cons_data_o,
  output logic [N_REQ-1:0]  gnt_o,
  output logic [ID_W-1:0]   gnt_id_o,
  output logic              burst_done_o,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  input  logic              fifo_rd_vld_i,
  output logic              fifo_rd_en_o
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  gnt_id_q, last_id_q, sel_id;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             burst_done_q, sel_vld;
  logic             in_burst, req_s, rdy_s, beat, last_beat;
  int               idx;

  // Scan downward so the lowest offset from last_id+1 is written last and wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    idx     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_id_q) + k) % N_REQ;
      if (req_i[idx[ID_W-1:0]]) begin
        sel_vld = 1'b1;
        sel_id  = idx[ID_W-1:0];
      end
    end
  end

  assign in_burst     = (state_q == BURST);
  assign req_s        = req_i[gnt_id_q];
  assign rdy_s        = cons_rdy_i[gnt_id_q];
  assign fifo_rd_en_o = in_burst & req_s & rdy_s;
  assign cons_vld_o   = (in_burst & fifo_rd_vld_i & req_s) ? gnt_q : '0;
  assign cons_data_o  = fifo_rd_data_i;
  assign beat         = fifo_rd_vld_i & fifo_rd_en_o;
  assign beat_cnt_d   = beat_cnt_q + CNT_W'(beat);
  assign last_beat    = beat && (beat_cnt_d == CNT_W'(BURST_LEN));

  assign gnt_o        = gnt_q;
  assign gnt_id_o     = gnt_id_q;
  assign burst_done_o = burst_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      last_id_q    <= ID_W'(N_REQ - 1);
      beat_cnt_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_vld) begin
            state_q    <= BURST;
            gnt_q      <= N_REQ'(1) << sel_id;
            gnt_id_q   <= sel_id;
            last_id_q  <= sel_id;
            beat_cnt_q <= '0;
          end
        end
        BURST: begin
          beat_cnt_q <= beat_cnt_d;
          // A beat needs req_s, so a drop and a final beat never collide.
          if (!req_s || last_beat) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            burst_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pix_buff_rd_arb.sv
// Bench for pix_buff_rd_arb: directed scenarios plus random traffic, all checked
// cycle by cycle against a grant/beat-count reference model.
module tb_pix_buff_rd_arb;

  localparam int NR = 4;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, rdy, cvld, gnt;
  logic [1:0]  gid;
  logic        done, fvld, fen;
  logic [31:0] fdata, cdata;

  pix_buff_rd_arb #(.N_REQ(NR), .DATA_W(32), .BURST_LEN(BL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .cons_rdy_i(rdy),
    .cons_vld_o(cvld), .cons_data_o(cdata), .gnt_o(gnt), .gnt_id_o(gid),
    .burst_done_o(done), .fifo_rd_data_i(fdata), .fifo_rd_vld_i(fvld),
    .fifo_rd_en_o(fen)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  // reference model: current grantee (-1 none), beats taken, last winner, pulse
  int m_cur, m_cnt, m_last, m_gid, seq;
  bit m_done;
  // observations of the DUT, for scenario-level checks
  int n_beats = 0, n_done = 0, n_other = 0;
  logic [3:0] s_gnt, s_prev;
  logic [1:0] s_id;
  logic       s_en, s_done;
  int rises[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_cnt = 0; m_last = NR - 1; m_gid = 0; m_done = 0; s_prev = '0;
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] c, input logic v);
    logic [3:0] e_gnt, e_vld;
    logic       e_en;
    bit         found;
    @(negedge clk);
    req = r; rdy = c; fvld = v; fdata = 32'(seq);
    #1;
    e_gnt = (m_cur >= 0) ? 4'(1 << m_cur) : 4'b0;
    e_en  = (m_cur >= 0) && r[m_cur] && c[m_cur];
    e_vld = (m_cur >= 0 && v && r[m_cur]) ? e_gnt : 4'b0;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("gnt_id", 32'(gid), 32'(m_gid));
    chk("burst_done", 32'(done), 32'(m_done));
    chk("rd_en", 32'(fen), 32'(e_en));
    chk("cons_vld", 32'(cvld), 32'(e_vld));
    chk("cons_data", cdata, 32'(seq));
    s_gnt = gnt; s_id = gid; s_en = fen; s_done = done;
    if (fen && fvld) n_beats++;
    if (done) n_done++;
    if ((cvld & ~req) != 0) n_other++;
    if (gnt != 0 && s_prev == 0) rises.push_back(int'(gid));
    s_prev = gnt;
    @(posedge clk);
    m_done = 0;
    if (m_cur < 0) begin
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        if (!found && r[(m_last + k) % NR]) begin
          found = 1; m_cur = (m_last + k) % NR;
        end
      end
      if (found) begin m_gid = m_cur; m_last = m_cur; m_cnt = 0; end
    end else begin
      if (e_en && v) begin m_cnt++; seq++; end
      if (!r[m_cur] || m_cnt == BL) begin m_cur = -1; m_done = 1; end
    end
  endtask

  int b0, d0;
  bit seen;
  logic [3:0] rr, cc;
  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    seq = 100;
    rst_n = 1'b0; req = '0; rdy = '0; fvld = 1'b0; fdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_gnt_id", 32'(gid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // all four requesting: 0,1,2,3,0 with one dead cycle between grants
    rises.delete(); b0 = n_beats; d0 = n_done;
    repeat (26) step(4'b1111, 4'b1111, 1'b1);
    chk("t1_ngrants", 32'(rises.size()), 32'd5);
    foreach (rises[j]) if (j < 5) chk("t1_order", 32'(rises[j]), 32'(exp_ord[j]));
    chk("t1_beats", 32'(n_beats - b0), 32'd20);
    chk("t1_dones", 32'(n_done - d0), 32'd5);

    // lone requester 2 re-granted after every idle cycle
    step(4'b0000, 4'b1111, 1'b1);
    rises.delete(); n_other = 0;
    repeat (15) step(4'b0100, 4'b1111, 1'b1);
    chk("t2_ngrants", 32'(rises.size()), 32'd3);
    foreach (rises[j]) chk("t2_id", 32'(rises[j]), 32'd2);
    chk("t2_other_vld", 32'(n_other), 32'd0);

    // consumer 1 abandons after 2 beats, pending 3 follows
    repeat (3) step(4'b0000, 4'b1111, 1'b1);
    step(4'b0010, 4'b1111, 1'b1);
    step(4'b1010, 4'b1111, 1'b1);
    step(4'b1010, 4'b1111, 1'b1);
    step(4'b1000, 4'b1111, 1'b1);
    chk("t3_drop_no_pop", 32'(s_en), 32'd0);
    step(4'b1000, 4'b1111, 1'b1);
    chk("t3_done", 32'(s_done), 32'd1);
    chk("t3_gnt_clear", 32'(s_gnt), 32'd0);
    step(4'b1000, 4'b1111, 1'b1);
    chk("t3_next_gnt", 32'(s_gnt), 32'b1000);
    repeat (2) step(4'b0000, 4'b1111, 1'b1);

    // FIFO starves for 5 cycles while cons_rdy toggles
    step(4'b0001, 4'b1111, 1'b1);
    b0 = n_beats; d0 = n_done; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cc = {3'($urandom), i[0]};
      step(4'b0001, cc, (i >= 1 && i < 6) ? 1'b0 : 1'b1);
      if (n_done > d0) seen = 1;
    end
    chk("t4_done_seen", 32'(seen), 32'd1);
    chk("t4_beats", 32'(n_beats - b0), 32'(BL));
    repeat (2) step(4'b0000, 4'b1111, 1'b1);

    // reset in the middle of a burst
    step(4'b1111, 4'b1111, 1'b1);
    step(4'b1111, 4'b1111, 1'b1);
    step(4'b1111, 4'b1111, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt", 32'(gnt), 32'd0);
    chk("rst_mid_vld", 32'(cvld), 32'd0);
    chk("rst_mid_en", 32'(fen), 32'd0);
    model_reset();
    req = 4'b1010;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_en", 32'(fen), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b1010, 4'b1111, 1'b1);
    step(4'b1010, 4'b1111, 1'b1);
    chk("t5_first_id", 32'(s_id), 32'd1);
    chk("t5_first_gnt", 32'(s_gnt), 32'b0010);

    // random traffic with sticky requests
    rr = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < NR; b++) if ($urandom_range(3) == 0) rr[b] = ~rr[b];
      step(rr, 4'($urandom), $urandom_range(3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
